// File: rtl/dot_sat_ctrl_pkg.sv
// Shared types and width helpers for the dot-product sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: FSM state enum, accumulator/counter width derivation and the
// Q-format saturation limits generalised to any result width.
package dot_sat_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_SAT  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Full signed product width plus guard bits so LEN_MAX worst-case
  // products can be summed without wrap.
  function automatic int acc_width(input int bit_width, input int guard);
    return 2 * bit_width + guard;
  endfunction

  // Enough bits to hold 0..len_max inclusive.
  function automatic int cnt_width(input int len_max);
    return $clog2(len_max + 1);
  endfunction

  // Largest positive Q value (0x7FFF for 16 bits), zero-extended to 64 bits.
  function automatic logic [63:0] q_max(input int bit_width);
    return (64'd1 << (bit_width - 1)) - 64'd1;
  endfunction

  // Most negative Q value (0x8000 for 16 bits); the low bit_width bits of
  // this 64-bit value are the result pattern.
  function automatic logic [63:0] q_min(input int bit_width);
    return ~q_max(bit_width);
  endfunction

endpackage

// File: rtl/dot_sat_ctrl_sat_q.sv
// Rescale a wide accumulator to Q(BIT_WIDTH-FRAC_WIDTH).FRAC_WIDTH with clipping.
// Latency: purely combinational.
// Backpressure: none; the caller registers res/clip when it needs them.
//
// Ports:
//   acc  - signed accumulator, ACC_W bits, FRAC_WIDTH*2 fractional bits
//   res  - rescaled result, BIT_WIDTH bits, clipped to the Q range
//   clip - high when res was forced to the positive or negative limit
// Build option: DOT_SAT_ROUND_EN adds half an LSB before the shift
// (round half up); without it the shift truncates toward -infinity.
module dot_sat_ctrl_sat_q
  import dot_sat_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ACC_W      = 36
) (
  input  logic signed [ACC_W-1:0]     acc,
  output logic        [BIT_WIDTH-1:0] res,
  output logic                        clip
);

  localparam logic [63:0] QMAX64 = q_max(BIT_WIDTH);
  localparam logic [63:0] QMIN64 = q_min(BIT_WIDTH);
  localparam logic [BIT_WIDTH-1:0] QMAX = QMAX64[BIT_WIDTH-1:0];
  localparam logic [BIT_WIDTH-1:0] QMIN = QMIN64[BIT_WIDTH-1:0];

`ifdef DOT_SAT_ROUND_EN
  // Half an output LSB. The guard bits leave headroom above the largest
  // reachable positive sum, so this addition cannot wrap.
  localparam logic [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_WIDTH - 1);
`endif

  logic signed [ACC_W-1:0]           biased;
  logic signed [ACC_W-1:0]           shifted;
  // Result sign bit plus everything above it: in range only if all equal.
  logic        [ACC_W-BIT_WIDTH:0]   upper;
  logic                              in_range;

  always_comb begin
`ifdef DOT_SAT_ROUND_EN
    biased = acc + $signed(HALF);
`else
    biased = acc;
`endif
    shifted  = biased >>> FRAC_WIDTH;
    upper    = shifted[ACC_W-1:BIT_WIDTH-1];
    in_range = (&upper) || !(|upper);

    res  = shifted[BIT_WIDTH-1:0];
    clip = 1'b0;
    if (!in_range) begin
      clip = 1'b1;
      res  = shifted[ACC_W-1] ? QMIN : QMAX;
    end
  end

endmodule

// File: rtl/dot_sat_ctrl.sv
// Sequencer for one saturating fixed-point dot product (len operand pairs).
// Latency: last input handshake at cycle N -> out_valid at N+2; len=0 -> T+1.
// Backpressure: in_ready only in ACC; result held in OUT until out_ready.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, len          - begin a dot product of len terms (IDLE only)
//   in_valid/in_ready   - operand pair handshake, operands a and b
//   out_valid/out_ready - result handshake, out_data and sat_flag
//   busy                - high whenever not in IDLE
// Build option: DOT_SAT_ROUND_EN selects round-half-up instead of truncation.
module dot_sat_ctrl
  import dot_sat_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int LEN_MAX    = 16,
  parameter int GUARD      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(LEN_MAX+1)-1:0]   len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [BIT_WIDTH-1:0]           a,
  input  logic [BIT_WIDTH-1:0]           b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BIT_WIDTH-1:0]           out_data,
  output logic                           sat_flag,
  output logic                           busy
);

  localparam int ACC_W = acc_width(BIT_WIDTH, GUARD);
  localparam int CNT_W = cnt_width(LEN_MAX);
  localparam int PW    = 2 * BIT_WIDTH;

  state_t state;
  state_t state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] cnt;
  logic        [CNT_W-1:0] cnt_inc;
  logic        [CNT_W-1:0] len_q;

  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    prod;
  logic        [ACC_W-1:0] prod_ext;
  logic                    in_fire;

  logic [BIT_WIDTH-1:0]    sat_res;
  logic                    sat_clip;

  // Operands widened first so the multiply is done at full product width.
  assign a_ext    = {{BIT_WIDTH{a[BIT_WIDTH-1]}}, a};
  assign b_ext    = {{BIT_WIDTH{b[BIT_WIDTH-1]}}, b};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{GUARD{prod[PW-1]}}, prod};
  assign cnt_inc  = cnt + CNT_W'(1);
  assign in_fire  = in_valid && in_ready;

  dot_sat_ctrl_sat_q #(
    .BIT_WIDTH  (BIT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .ACC_W      (ACC_W)
  ) u_sat_q (
    .acc  (acc),
    .res  (sat_res),
    .clip (sat_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (len == '0) ? ST_OUT : ST_ACC;
        end
      end
      ST_ACC: begin
        in_ready = 1'b1;
        // len_q >= 1 here, so cnt_inc == len_q marks the final term.
        if (in_valid && (cnt_inc == len_q)) begin
          state_nxt = ST_SAT;
        end
      end
      ST_SAT: begin
        state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q    <= len;
            acc      <= '0;
            cnt      <= '0;
            // A zero-length product goes straight to OUT with a zero result.
            out_data <= '0;
            sat_flag <= 1'b0;
          end
        end
        ST_ACC: begin
          if (in_fire) begin
            acc <= acc + prod_ext;
            cnt <= cnt_inc;
          end
        end
        ST_SAT: begin
          out_data <= sat_res;
          sat_flag <= sat_clip;
        end
        default: begin
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Lengths beyond LEN_MAX could overflow the guard bits.
  always @(posedge clk) begin
    if (!rst && (state == ST_IDLE) && start) begin
      assert (len <= CNT_W'(LEN_MAX))
        else $error("dot_sat_ctrl: len %0d exceeds LEN_MAX %0d", len, LEN_MAX);
    end
  end
`endif

endmodule

// File: tb/tb_dot_sat_ctrl.sv
// Self-checking bench for dot_sat_ctrl: directed cases then randomized
// dot products, compared against an arithmetic reference model.
module tb_dot_sat_ctrl;

  localparam int BW = 16;
  localparam int FW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        sat_flag;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always #5 clk = ~clk;

  dot_sat_ctrl #(
    .BIT_WIDTH  (BW),
    .FRAC_WIDTH (FW),
    .LEN_MAX    (16),
    .GUARD      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer sum of products, then scale/round/clip.
  function automatic void model(input int n, output logic [15:0] r, output logic f);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s += longint'(shortint'(qa[i])) * longint'(shortint'(qb[i]));
    end
`ifdef DOT_SAT_ROUND_EN
    s += 128;
`endif
    s = s >>> FW;
    f = 1'b1;
    if (s > 32767) begin
      r = 16'h7FFF;
    end else if (s < -32768) begin
      r = 16'h8000;
    end else begin
      r = s[15:0];
      f = 1'b0;
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  in_ready,  0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".out_data"},  out_data,  0);
    check({tag, ".sat_flag"},  sat_flag,  0);
    check({tag, ".busy"},      busy,      0);
  endtask

  // One complete dot product over qa/qb[0..n-1]. gap = % chance of an idle
  // in_valid cycle, hold = cycles out_ready stays low while start toggles.
  task automatic run_dot(input int n, input int gap, input int hold, input string tag);
    logic [15:0] er;
    logic        ef;
    int          idx;
    int          guard;
    logic        hs;
    model(n, er, ef);
    check({tag, ".idle_busy"}, busy, 0);
    start = 1'b1;
    len   = n[4:0];
    tick();
    start = 1'b0;
    if (n == 0) begin
      check({tag, ".len0_valid"}, out_valid, 1);
      check({tag, ".len0_ready"}, in_ready, 0);
    end else begin
      idx   = 0;
      guard = 0;
      while (idx < n && guard < 1000) begin
        in_valid = ($urandom_range(99) >= gap);
        if (in_valid) begin
          a = qa[idx];
          b = qb[idx];
        end else begin
          a = 16'($urandom);
          b = 16'($urandom);
        end
        check({tag, ".acc_ready"}, in_ready, 1);
        hs = in_valid;
        tick();
        if (hs) idx++;
        guard++;
      end
      in_valid = 1'b0;
      a = '0;
      b = '0;
      check({tag, ".feed_done"}, idx, n);
      // Cycle N+1: SAT, nothing presented yet.
      check({tag, ".sat_valid"}, out_valid, 0);
      check({tag, ".sat_ready"}, in_ready, 0);
      check({tag, ".sat_busy"},  busy, 1);
      tick();
      check({tag, ".lat_valid"}, out_valid, 1);
    end
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      start     = 1'($urandom_range(1));
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_data"},  out_data, er);
      check({tag, ".hold_sat"},   sat_flag, ef);
      check({tag, ".hold_busy"},  busy, 1);
      check({tag, ".hold_ready"}, in_ready, 0);
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".out_data"},  out_data, er);
    check({tag, ".sat_flag"},  sat_flag, ef);
    tick();
    out_ready = 1'b0;
    check({tag, ".post_valid"}, out_valid, 0);
    check({tag, ".post_busy"},  busy, 0);
  endtask

  task automatic set2(input logic [15:0] a0, input logic [15:0] b0);
    qa.push_back(a0);
    qb.push_back(b0);
  endtask

  initial begin
    int n;
    int v;
    int mode;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    a = '0; b = '0; out_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check("reset_idle_busy", busy, 0);

    // Basic two-term product: 1*2 + 1.5*1 = 3.5.
    qa.delete(); qb.delete();
    set2(16'h0100, 16'h0200); set2(16'h0180, 16'h0100);
    run_dot(2, 0, 0, "basic");

    // Positive saturation.
    qa.delete(); qb.delete();
    for (int i = 0; i < 4; i++) set2(16'h7FFF, 16'h7FFF);
    run_dot(4, 0, 1, "satpos");

    // Negative saturation.
    qa.delete(); qb.delete();
    for (int i = 0; i < 2; i++) set2(16'h8000, 16'h7FFF);
    run_dot(2, 0, 0, "satneg");

    // Zero length.
    run_dot(0, 0, 2, "len0");

    // Gaps on input, long output stall with start pulses.
    qa.delete(); qb.delete();
    set2(16'h0040, 16'hFF00); set2(16'h0300, 16'h0120); set2(16'hFE80, 16'h0055);
    run_dot(3, 50, 5, "stall");

    // Half-LSB product: truncates to 0, rounds to 1.
    qa.delete(); qb.delete();
    set2(16'h0001, 16'h0080);
    run_dot(1, 0, 0, "round");

    // Reset mid-accumulation discards the partial sum.
    start = 1'b1; len = 5'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a = 16'h7000; b = 16'h7000;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_acc");
    rst = 1'b0;
    tick();
    qa.delete(); qb.delete();
    set2(16'h0100, 16'h0100);
    run_dot(1, 0, 0, "after_rst");

    // Reset while a nonzero result is presented.
    start = 1'b1; len = 5'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a = 16'h0200; b = 16'h0100;
    tick();
    in_valid = 1'b0;
    tick();
    check("rst_out.pre_valid", out_valid, 1);
    check("rst_out.pre_data", out_data, 16'h0200);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_out");
    rst = 1'b0;
    tick();

    // Randomized products across lengths, operand ranges and flow patterns.
    for (int k = 0; k < 30; k++) begin
      n    = $urandom_range(0, 16);
      mode = $urandom_range(0, 2);
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
        case (mode)
          0: set2(16'($urandom), 16'($urandom));
          1: begin
            v = $urandom_range(0, 2047) - 1024;
            qa.push_back(v[15:0]);
            v = $urandom_range(0, 2047) - 1024;
            qb.push_back(v[15:0]);
          end
          default: set2($urandom_range(1) ? 16'h7FFF : 16'h8000,
                        $urandom_range(1) ? 16'h7FFF : 16'h8000);
        endcase
      end
      run_dot(n, $urandom_range(0, 50), $urandom_range(0, 3), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
